fpu_cpx_merge: RTL and testbench
================================

FPU_CPX_MERGE -- requirements
Module: fpu_cpx_merge

Interface
REQ-001 SHALL have parameter SIZE, default 8, number of FPU lanes merged (2..16).
REQ-002 SHALL have parameter DEPTH, default 2, result buffer entries per lane (power of 2, >=2).
REQ-003 SHALL have port gclk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port arst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port lane_req_cq  input  SIZE*8  per-lane CPX request; lane i occupies bits [8i+7:8i].
REQ-006 SHALL have port lane_data_ca  input  SIZE*145  per-lane result; lane i occupies bits [145i+144:145i]; valid one cycle after that lane's nonzero request.
REQ-007 SHALL have port cpx_busy  input  1  CPX cannot accept a new request this cycle.
REQ-008 SHALL have port fp_cpx_req_cq  output  8  merged FPU result request to CPX.
REQ-009 SHALL have port fp_cpx_data_ca  output  145  merged FPU result, one cycle after its request.
REQ-010 SHALL have port lane_ovf  output  SIZE  sticky per-lane buffer-overflow flag.
REQ-011 SHALL have port merge_idle  output  1  high when all lane buffers are empty and no output transfer is in flight.

Function
REQ-012 SHALL treat a lane as requesting in cycle t when its 8-bit lane_req_cq is nonzero.
REQ-013 SHALL register the request value at t and write {req, lane_data_ca of cycle t+1} into that lane's buffer at the end of t+1.
REQ-014 SHALL accept a new lane request every cycle; capture of request t+1 overlaps data capture of request t.
REQ-015 SHALL keep each lane buffer FIFO-ordered with a count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-016 SHALL, when a write targets a full lane buffer and no pop from that lane occurs in the same cycle, drop the entry, leave buffer contents unchanged, and set lane_ovf[i].
REQ-017 SHALL accept a write to a full lane buffer when a pop from that lane occurs in the same cycle, with no overflow.
REQ-018 SHALL keep lane_ovf bits set until reset.
REQ-019 SHALL, in each cycle with cpx_busy low and at least one nonempty buffer, grant exactly one lane by round-robin starting at the lane after the last granted lane; the first grant after reset searches from lane 0.
REQ-020 SHALL pop the granted lane's head entry in the grant cycle.
REQ-021 SHALL drive fp_cpx_req_cq with the popped request in the cycle after the grant and drive fp_cpx_data_ca with the popped data in the cycle after that.
REQ-022 SHALL drive fp_cpx_req_cq to 8'h00 in any cycle without a granted transfer, and fp_cpx_data_ca to zero in any cycle not following a nonzero fp_cpx_req_cq.
REQ-023 SHALL, with cpx_busy high, grant nothing and pop nothing; buffered entries wait without loss.
REQ-024 SHALL sustain one output transfer per cycle, back-to-back, for as long as entries are available and cpx_busy stays low.
REQ-025 SHALL have a minimum latency of 3 cycles from a lane request (cycle t) to fp_cpx_req_cq (cycle t+3).
REQ-026 SHALL preserve per-lane result order; interleaving across lanes follows round-robin order only.
REQ-027 SHALL drive merge_idle low when any buffer count is nonzero, any lane capture is pending, or fp_cpx_req_cq/fp_cpx_data_ca is active.

Reset
REQ-028 SHALL, while arst is high, immediately clear all buffer counts and pointers, pending captures, the round-robin pointer, lane_ovf, fp_cpx_req_cq and fp_cpx_data_ca, and drive merge_idle high.
REQ-029 SHALL discard any in-flight capture or output transfer when arst is asserted mid-operation; after release, no stale request or data appears.

Verification
REQ-030 Lane 3 req 8'h81 at t, data D at t+1 -> fp_cpx_req_cq=8'h81 at t+3, fp_cpx_data_ca=D at t+4, merge_idle high at t+5.
REQ-031 Lanes 0, 2 and 5 request in the same cycle, with the last grant on lane 2 -> outputs in order lane 5, 0, 2 on consecutive cycles.
REQ-032 Lane 1 issues 3 back-to-back requests with cpx_busy held high and DEPTH=2 -> the first 2 are kept and the 3rd is dropped, lane_ovf[1]=1; on cpx_busy release, exactly 2 outputs appear in order.
REQ-033 Lane 1 buffer is full, and a pop from lane 1 and a new capture on lane 1 occur in the same cycle -> no overflow, the count stays 2, and FIFO order holds.
REQ-034 arst is asserted one cycle after fp_cpx_req_cq goes nonzero -> fp_cpx_data_ca=0, lane_ovf=0 and merge_idle=1 immediately, with no output after release.

Source files
------------

// File: rtl/fpu_cpx_merge.sv
// fpu_cpx_merge: merges per-lane FPU results into a single CPX request/data
// stream. Each lane has a small FIFO. A round-robin arbiter drains the FIFOs
// into a two-stage output: request first, then data one cycle later.
module fpu_cpx_merge #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                gclk,
  input  logic                arst,
  input  logic [SIZE*8-1:0]   lane_req_cq,
  input  logic [SIZE*145-1:0] lane_data_ca,
  input  logic                cpx_busy,
  output logic [7:0]          fp_cpx_req_cq,
  output logic [144:0]        fp_cpx_data_ca,
  output logic [SIZE-1:0]     lane_ovf,
  output logic                merge_idle
);

  localparam int unsigned LW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [152:0] entry_t;

  logic [7:0]    pend_q [SIZE];
  logic [PW-1:0] wptr_q [SIZE];
  logic [PW-1:0] rptr_q [SIZE];
  logic [CW-1:0] cnt_q  [SIZE];
  entry_t        mem_q  [SIZE][DEPTH];

  logic [SIZE-1:0] wr_req;
  logic [SIZE-1:0] wr_acc;
  logic [SIZE-1:0] ovf_set;
  logic [SIZE-1:0] nonempty;
  logic [SIZE-1:0] pop_en;
  logic [SIZE-1:0] ovf_q;
  logic            pend_any;

  logic [LW-1:0]   rr_q;
  logic [LW-1:0]   gnt_idx;
  logic            gnt_vld;
  entry_t          head;

  logic [7:0]      req_q;
  logic [144:0]    dhold_q;
  logic [144:0]    data_q;
  logic            dval_q;

  // Per-lane write decision: a pop from a full lane frees the slot being written.
  always_comb begin
    wr_req   = '0;
    wr_acc   = '0;
    ovf_set  = '0;
    nonempty = '0;
    pend_any = 1'b0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      wr_req[i]   = (pend_q[i] != 8'h00);
      nonempty[i] = (cnt_q[i] != '0);
      pend_any    = pend_any | wr_req[i];
      if (wr_req[i]) begin
        if ((cnt_q[i] != CW'(DEPTH)) || pop_en[i]) wr_acc[i] = 1'b1;
        else                                        ovf_set[i] = 1'b1;
      end
    end
  end

  // Round-robin search starting at the lane after the last grant.
  always_comb begin
    int unsigned idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    pop_en  = '0;
    idx     = 0;
    if (!cpx_busy) begin
      for (int unsigned k = 0; k < SIZE; k++) begin
        idx = 32'(rr_q) + k;
        if (idx >= SIZE) idx = idx - SIZE;
        if (!gnt_vld && nonempty[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = LW'(idx);
        end
      end
    end
    if (gnt_vld) pop_en = SIZE'(1) << gnt_idx;
    head = mem_q[gnt_idx][rptr_q[gnt_idx]];
  end

  // Request capture, FIFO pointers/counts and sticky overflow flags.
  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        pend_q[i] <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        pend_q[i] <= lane_req_cq[8*i +: 8];
        if (wr_acc[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
        if (pop_en[i]) rptr_q[i] <= rptr_q[i] + PW'(1);
        if (wr_acc[i] && !pop_en[i])      cnt_q[i] <= cnt_q[i] + CW'(1);
        else if (!wr_acc[i] && pop_en[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
      end
      ovf_q <= ovf_q | ovf_set;
    end
  end

  // FIFO storage; validity is tracked by the counts, so no reset is needed.
  always_ff @(posedge gclk) begin
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (wr_acc[i]) mem_q[i][wptr_q[i]] <= {pend_q[i], lane_data_ca[145*i +: 145]};
    end
  end

  // Output pipeline and round-robin pointer update.
  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      req_q   <= '0;
      dhold_q <= '0;
      data_q  <= '0;
      dval_q  <= 1'b0;
      rr_q    <= '0;
    end else begin
      if (gnt_vld) begin
        req_q   <= head[152:145];
        dhold_q <= head[144:0];
        rr_q    <= (gnt_idx == LW'(SIZE - 1)) ? '0 : gnt_idx + LW'(1);
      end else begin
        req_q   <= '0;
        dhold_q <= '0;
      end
      data_q <= dhold_q;
      dval_q <= (req_q != 8'h00);
    end
  end

  // Idle when nothing is buffered, pending capture, or on the output.
  always_comb begin
    merge_idle = !(|nonempty) && !pend_any && (req_q == 8'h00) && !dval_q;
  end

  assign fp_cpx_req_cq  = req_q;
  assign fp_cpx_data_ca = data_q;
  assign lane_ovf       = ovf_q;

endmodule

// File: tb/tb_fpu_cpx_merge.sv
// Directed bench for fpu_cpx_merge (SIZE=8, DEPTH=2).
module tb_fpu_cpx_merge;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned DEPTH = 2;

  logic                gclk = 1'b0;
  logic                arst = 1'b1;
  logic [SIZE*8-1:0]   lane_req_cq = '0;
  logic [SIZE*145-1:0] lane_data_ca = '0;
  logic                cpx_busy = 1'b0;
  logic [7:0]          fp_cpx_req_cq;
  logic [144:0]        fp_cpx_data_ca;
  logic [SIZE-1:0]     lane_ovf;
  logic                merge_idle;

  int passed = 0;
  int total  = 0;

  fpu_cpx_merge #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .gclk           (gclk),
    .arst           (arst),
    .lane_req_cq    (lane_req_cq),
    .lane_data_ca   (lane_data_ca),
    .cpx_busy       (cpx_busy),
    .fp_cpx_req_cq  (fp_cpx_req_cq),
    .fp_cpx_data_ca (fp_cpx_data_ca),
    .lane_ovf       (lane_ovf),
    .merge_idle     (merge_idle)
  );

  always #5 gclk = ~gclk;

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_req(input int lane, input logic [7:0] v);
    lane_req_cq[lane*8 +: 8] = v;
  endtask

  task automatic set_dat(input int lane, input logic [144:0] v);
    lane_data_ca[lane*145 +: 145] = v;
  endtask

  task automatic clr_in();
    lane_req_cq  = '0;
    lane_data_ca = '0;
  endtask

  logic [144:0] d_a, d0, d2, d5, da1, da2, da3, db1, db2, db3, dc4, d6;

  initial begin
    d_a = {1'b1, 144'h0123_4567_89AB_CDEF_0000_1111_2222_3333_4444};
    d0  = 145'h1000;
    d2  = 145'h2222_0000;
    d5  = {1'b1, 144'h5555};
    da1 = 145'hA1;
    da2 = 145'hA2A2;
    da3 = 145'hA3A3A3;
    db1 = 145'hB1;
    db2 = 145'hB2B2;
    db3 = 145'hB3B3B3;
    dc4 = 145'hC4C4_C4C4;
    d6  = 145'h6666;

    // Reset state
    #2;
    chk("rst_req",  fp_cpx_req_cq, 8'h00);
    chk("rst_data", fp_cpx_data_ca, 145'h0);
    chk("rst_ovf",  lane_ovf, 8'h00);
    chk("rst_idle", merge_idle, 1'b1);
    step(); step();
    arst = 1'b0;

    // Single lane-3 transfer: req at t+3, data at t+4, idle at t+5
    step(); set_req(3, 8'h81);
    chk("t1_idle0", merge_idle, 1'b1);
    step(); clr_in(); set_dat(3, d_a);
    chk("t1_busy1", merge_idle, 1'b0);
    step(); clr_in();
    chk("t1_req2", fp_cpx_req_cq, 8'h00);
    step();
    chk("t1_req3", fp_cpx_req_cq, 8'h81);
    chk("t1_dat3", fp_cpx_data_ca, 145'h0);
    step();
    chk("t1_req4", fp_cpx_req_cq, 8'h00);
    chk("t1_dat4", fp_cpx_data_ca, d_a);
    chk("t1_idle4", merge_idle, 1'b0);
    step();
    chk("t1_idle5", merge_idle, 1'b1);
    chk("t1_dat5", fp_cpx_data_ca, 145'h0);

    // Make lane 2 the last granted lane
    step(); set_req(2, 8'h02);
    step(); clr_in(); set_dat(2, 145'h77);
    step(); clr_in();
    step();
    chk("rr2_req", fp_cpx_req_cq, 8'h02);
    step(); step(); step();

    // Lanes 0, 2, 5 together: order 5, 0, 2
    set_req(0, 8'h10); set_req(2, 8'h22); set_req(5, 8'h55);
    step(); clr_in(); set_dat(0, d0); set_dat(2, d2); set_dat(5, d5);
    step(); clr_in();
    step();
    chk("rr_req_a", fp_cpx_req_cq, 8'h55);
    step();
    chk("rr_req_b", fp_cpx_req_cq, 8'h10);
    chk("rr_dat_a", fp_cpx_data_ca, d5);
    step();
    chk("rr_req_c", fp_cpx_req_cq, 8'h22);
    chk("rr_dat_b", fp_cpx_data_ca, d0);
    step();
    chk("rr_req_d", fp_cpx_req_cq, 8'h00);
    chk("rr_dat_c", fp_cpx_data_ca, d2);
    step();
    chk("rr_idle", merge_idle, 1'b1);

    // Overflow on lane 1 with cpx_busy high
    cpx_busy = 1'b1; set_req(1, 8'hA1);
    step(); clr_in(); set_req(1, 8'hA2); set_dat(1, da1);
    step(); clr_in(); set_req(1, 8'hA3); set_dat(1, da2);
    step(); clr_in(); set_dat(1, da3);
    step(); clr_in();
    chk("ovf_set", lane_ovf, 8'h02);
    chk("ovf_busy_req", fp_cpx_req_cq, 8'h00);
    step(); cpx_busy = 1'b0;
    chk("ovf_sticky", lane_ovf, 8'h02);
    step();
    chk("ovf_req1", fp_cpx_req_cq, 8'hA1);
    step();
    chk("ovf_req2", fp_cpx_req_cq, 8'hA2);
    chk("ovf_dat1", fp_cpx_data_ca, da1);
    step();
    chk("ovf_req3", fp_cpx_req_cq, 8'h00);
    chk("ovf_dat2", fp_cpx_data_ca, da2);
    step();
    chk("ovf_dat3", fp_cpx_data_ca, 145'h0);
    chk("ovf_idle", merge_idle, 1'b1);

    // Reset clears sticky overflow
    arst = 1'b1; #1;
    chk("rst2_ovf", lane_ovf, 8'h00);
    chk("rst2_idle", merge_idle, 1'b1);
    step(); arst = 1'b0;

    // Full lane 1: pop and write in the same cycle
    step(); cpx_busy = 1'b1; set_req(1, 8'hB1);
    step(); clr_in(); set_req(1, 8'hB2); set_dat(1, db1);
    step(); clr_in(); set_req(1, 8'hB3); set_dat(1, db2);
    step(); clr_in(); set_dat(1, db3); cpx_busy = 1'b0;
    chk("sim_req0", fp_cpx_req_cq, 8'h00);
    step(); clr_in();
    chk("sim_req1", fp_cpx_req_cq, 8'hB1);
    step();
    chk("sim_req2", fp_cpx_req_cq, 8'hB2);
    chk("sim_dat1", fp_cpx_data_ca, db1);
    step();
    chk("sim_req3", fp_cpx_req_cq, 8'hB3);
    chk("sim_dat2", fp_cpx_data_ca, db2);
    step();
    chk("sim_req4", fp_cpx_req_cq, 8'h00);
    chk("sim_dat3", fp_cpx_data_ca, db3);
    chk("sim_noovf", lane_ovf, 8'h00);
    step();
    chk("sim_idle", merge_idle, 1'b1);

    // Reset during an output transfer
    set_req(4, 8'hC4);
    step(); clr_in(); set_dat(4, dc4);
    step(); clr_in(); set_req(6, 8'h66);
    step(); clr_in(); set_dat(6, d6);
    chk("mr_req", fp_cpx_req_cq, 8'hC4);
    step(); clr_in();
    arst = 1'b1; #1;
    chk("mr_dat", fp_cpx_data_ca, 145'h0);
    chk("mr_reqz", fp_cpx_req_cq, 8'h00);
    chk("mr_ovf", lane_ovf, 8'h00);
    chk("mr_idle", merge_idle, 1'b1);
    step(); step(); arst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("post_req", fp_cpx_req_cq, 8'h00);
      chk("post_dat", fp_cpx_data_ca, 145'h0);
      chk("post_idle", merge_idle, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
